// File: rtl/chien_search_pkg.sv
// Shared GF(2^16) definitions for the Chien search: field constants, FSM encoding
// and the alpha^-i step table for the locator terms.
package chien_search_pkg;

  localparam int              GF_M    = 16;
  localparam int              GF_T    = 12;
  localparam logic [GF_M:0]   GF_POLY = 17'h1100B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef logic [GF_T:0][GF_M-1:0] coef_tab_t;

  function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a,
                                              input logic [GF_M-1:0] b,
                                              input logic [GF_M-1:0] red);
    logic [GF_M-1:0] p;
    logic [GF_M-1:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < GF_M; k++) begin
      if (b[k]) p ^= aa;
      aa = aa[GF_M-1] ? ((aa << 1) ^ red) : (aa << 1);
    end
    return p;
  endfunction

  // The generator has a unit constant term, so x^-1 is simply (poly - 1) / x.
  function automatic coef_tab_t build_alpha_inv_tab(input logic [GF_M:0] poly);
    coef_tab_t       tab;
    logic [GF_M-1:0] ainv;
    ainv      = poly[GF_M:1];
    tab       = '0;
    tab[0][0] = 1'b1;
    for (int i = 1; i <= GF_T; i++) tab[i] = gf_mul(tab[i-1], ainv, poly[GF_M-1:0]);
    return tab;
  endfunction

  localparam coef_tab_t ALPHA_INV_TAB = build_alpha_inv_tab(GF_POLY);

endpackage

// File: rtl/chien_search_gf_const_mul.sv
// Combinational GF(2^16) multiply by a fixed field constant.
module gf_const_mul
  import chien_search_pkg::*;
#(
  parameter logic [GF_M-1:0] CONST = GF_M'(1),
  parameter logic [GF_M:0]   POLY  = GF_POLY
) (
  input  logic [GF_M-1:0] a_i,
  output logic [GF_M-1:0] p_o
);

  assign p_o = gf_mul(a_i, CONST, POLY[GF_M-1:0]);

endmodule

// File: rtl/chien_search.sv
// Chien search: evaluates the BM error locator at alpha^-j for j = 0..N-1, one
// position per cycle, and reports roots, root count and a degree-mismatch flag.
module chien_search
  import chien_search_pkg::*;
#(
  parameter int            M         = GF_M,
  parameter int            T         = GF_T,
  parameter int            N         = 2048,
  parameter logic [GF_M:0] PRIM_POLY = GF_POLY
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         enablechian,
  input  logic [M-1:0] miu0, miu1, miu2, miu3, miu4, miu5, miu6,
  input  logic [M-1:0] miu7, miu8, miu9, miu10, miu11, miu12,
  output logic         busy,
  output logic         err_pos_valid,
  output logic [15:0]  err_index,
  output logic         err_flag,
  output logic         done,
  output logic [4:0]   root_cnt,
  output logic         fail
);

  localparam int          DEG_W    = $clog2(T + 1);
  localparam logic [15:0] LAST_POS = 16'(N - 1);
  localparam coef_tab_t   AINV_TAB = build_alpha_inv_tab(PRIM_POLY);

  function automatic logic [4:0] sat_inc(input logic [4:0] c, input logic inc);
    if (inc && (c != 5'd31)) return c + 5'd1;
    return c;
  endfunction

  logic [T:0][M-1:0] miu, r_q, r_d, prod;
  logic [1:0]        state_q, state_d;
  logic [15:0]       j_q, j_d, idx_q, idx_d;
  logic [DEG_W-1:0]  deg_q, deg_d, deg_new;
  logic [4:0]        cnt_q, cnt_d;
  logic              fail_q, fail_d, valid_q, valid_d, flag_q, flag_d, done_q, done_d;
  logic              en_q, start, hit;
  logic [M-1:0]      sum;

  assign miu = {miu12, miu11, miu10, miu9, miu8, miu7, miu6,
                miu5, miu4, miu3, miu2, miu1, miu0};

  // A start is only a fresh rising edge seen while idle; edges during a search are dropped.
  assign start = enablechian & ~en_q & (state_q == S_IDLE);

  assign prod[0] = r_q[0];
  for (genvar i = 1; i <= T; i++) begin : g_step
    gf_const_mul #(.CONST(AINV_TAB[i]), .POLY(PRIM_POLY)) u_mul (
      .a_i (r_q[i]),
      .p_o (prod[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= T; i++) sum ^= r_q[i];
  end

  assign hit = (sum == '0);

  always_comb begin
    deg_new = '0;
    for (int i = 1; i <= T; i++) begin
      if (miu[i] != '0) deg_new = DEG_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    r_d     = r_q;
    deg_d   = deg_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    flag_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EVAL;
          j_d     = '0;
          r_d     = miu;
          cnt_d   = '0;
          fail_d  = 1'b0;
          deg_d   = deg_new;
        end
      end
      S_EVAL: begin
        r_d     = prod;
        j_d     = j_q + 16'd1;
        valid_d = 1'b1;
        idx_d   = j_q;
        flag_d  = hit;
        cnt_d   = sat_inc(cnt_q, hit);
        // Final count includes this last position, so done and fail line up with it.
        if (j_q == LAST_POS) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail_d  = (cnt_d != 5'(deg_q));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      r_q     <= '0;
      j_q     <= '0;
      deg_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= enablechian;
      r_q     <= r_d;
      j_q     <= j_d;
      deg_q   <= deg_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign err_pos_valid = valid_q;
  assign err_index     = idx_q;
  assign err_flag      = flag_q;
  assign done          = done_q;
  assign root_cnt      = cnt_q;
  assign fail          = fail_q;

endmodule
